track_motor_driver: RTL and testbench

TRACK_MOTOR_DRIVER -- requirements
Module: track_motor_driver

---
 rtl/track_motor_driver.sv | 241 ++++++++++++++++++++++++
 tb/tb_track_motor_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/track_motor_driver.sv
// track_motor_driver
//   Two-track (left/right) H-bridge PWM driver with soft ramping, a coast
//   dead-time before every direction change, and brake support.
//
// Ports
//   clk        system clock (shared with the PIO command register)
//   reset_n    asynchronous, active-low reset
//   cmd[3:0]   [1:0] left, [3:2] right: 00 stop, 01 fwd, 10 rev, 11 brake
//   enable     global drive enable; low forces both tracks to coast in STOP
//   pwm_l/r    registered PWM drive per track
//   dir_l/r    direction per track, 1 forward / 0 reverse
//   brake_l/r  active-high H-bridge brake per track
//   busy[1:0]  [0] left, [1] right; high outside STOP and BRAKE
module track_motor_driver #(
  parameter int unsigned PRESCALE   = 49,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned DEAD_TICKS = 100,
  parameter int unsigned MAX_DUTY   = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cmd,
  input  logic       enable,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       brake_l,
  output logic       brake_r,
  output logic [1:0] busy
);

  typedef enum logic [2:0] {
    ST_STOP      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_DEAD      = 3'd4,
    ST_BRAKE     = 3'd5
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE);
  localparam logic [15:0] RAMP_LAST  = 16'(RAMP_DIV - 1);
  localparam logic [15:0] DEAD_LAST  = 16'(DEAD_TICKS - 1);
  localparam logic [7:0]  MAX_D      = 8'(MAX_DUTY);

  localparam logic [1:0] REQ_STOP  = 2'b00;
  localparam logic [1:0] REQ_FWD   = 2'b01;
  localparam logic [1:0] REQ_REV   = 2'b10;
  localparam logic [1:0] REQ_BRAKE = 2'b11;

  logic [15:0] presc_q, presc_d;
  logic        tick_s;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [3:0]  cmd_q;

  state_t           state_q [2];
  state_t           state_d [2];
  logic [1:0][7:0]  duty_q, duty_d;
  logic [1:0][15:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pwm_q, pwm_d;
  logic [1:0]       brake_q, brake_d;
  logic [1:0]       busy_q, busy_d;

  // Prescaler and shared PWM counter next-state.
  always_comb begin
    tick_s    = (presc_q == PRESC_LAST);
    presc_d   = tick_s ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d = tick_s ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // Per-track FSM next-state, duty, ramp/dead counter and output decode.
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      logic [1:0] req;
      logic       step;
      logic       same_dir;
      logic       leave;
      req      = cmd_q[2*t +: 2];
      step     = 1'b0;
      state_d[t] = state_q[t];
      duty_d[t]  = duty_q[t];
      dir_d[t]   = dir_q[t];
      cnt_d[t]   = cnt_q[t];
      // Request matching the current direction, and request that means "slow down".
      same_dir = ((req == REQ_FWD) && dir_q[t]) || ((req == REQ_REV) && !dir_q[t]);
      leave    = (req == REQ_STOP) || ((req == REQ_FWD) && !dir_q[t]) ||
                 ((req == REQ_REV) && dir_q[t]);

      // The step counter only runs in the ramp states.
      if ((state_q[t] == ST_RAMP_UP) || (state_q[t] == ST_RAMP_DOWN)) begin
        if (tick_s) begin
          if (cnt_q[t] >= RAMP_LAST) begin
            step     = 1'b1;
            cnt_d[t] = 16'd0;
          end else begin
            cnt_d[t] = cnt_q[t] + 16'd1;
          end
        end else begin
          cnt_d[t] = cnt_q[t];
        end
      end else begin
        step = 1'b0;
      end

      case (state_q[t])
        ST_STOP: begin
          duty_d[t] = 8'd0;
          if (req == REQ_FWD) begin
            dir_d[t]   = 1'b1;
            state_d[t] = ST_RAMP_UP;
          end else if (req == REQ_REV) begin
            dir_d[t]   = 1'b0;
            state_d[t] = ST_RAMP_UP;
          end else if (req == REQ_BRAKE) begin
            state_d[t] = ST_BRAKE;
          end else begin
            state_d[t] = ST_STOP;
          end
        end
        ST_RAMP_UP: begin
          if (leave) begin
            state_d[t] = ST_RAMP_DOWN;
          end else if (duty_q[t] >= MAX_D) begin
            state_d[t] = ST_RUN;
            duty_d[t]  = MAX_D;
          end else if (step) begin
            duty_d[t] = duty_q[t] + 8'd1;
          end else begin
            duty_d[t] = duty_q[t];
          end
        end
        ST_RUN: begin
          duty_d[t] = MAX_D;
          if (leave) begin
            state_d[t] = ST_RAMP_DOWN;
          end else begin
            state_d[t] = ST_RUN;
          end
        end
        ST_RAMP_DOWN: begin
          if (same_dir) begin
            state_d[t] = ST_RAMP_UP;
          end else if (duty_q[t] == 8'd0) begin
            state_d[t] = ST_DEAD;
          end else if (step) begin
            duty_d[t] = duty_q[t] - 8'd1;
          end else begin
            duty_d[t] = duty_q[t];
          end
        end
        ST_DEAD: begin
          duty_d[t] = 8'd0;
          if (tick_s) begin
            if (cnt_q[t] >= DEAD_LAST) begin
              state_d[t] = ST_STOP;
            end else begin
              cnt_d[t] = cnt_q[t] + 16'd1;
            end
          end else begin
            cnt_d[t] = cnt_q[t];
          end
        end
        ST_BRAKE: begin
          duty_d[t] = 8'd0;
          if (req != REQ_BRAKE) begin
            state_d[t] = ST_DEAD;
          end else begin
            state_d[t] = ST_BRAKE;
          end
        end
        default: begin
          state_d[t] = ST_STOP;
          duty_d[t]  = 8'd0;
        end
      endcase

      // Brake beats the normal transitions; disable beats everything.
      if (!enable) begin
        state_d[t] = ST_STOP;
        duty_d[t]  = 8'd0;
      end else if (req == REQ_BRAKE) begin
        state_d[t] = ST_BRAKE;
        duty_d[t]  = 8'd0;
      end else begin
        state_d[t] = state_d[t];
      end

      // Every state entry restarts the ramp/dead counter.
      if (state_d[t] != state_q[t]) begin
        cnt_d[t] = 16'd0;
      end else begin
        cnt_d[t] = cnt_d[t];
      end

      // Outputs are decoded from next state so they line up with the FSM register.
      pwm_d[t]   = (pwm_cnt_q < duty_d[t]);
      brake_d[t] = (state_d[t] == ST_BRAKE);
      busy_d[t]  = (state_d[t] != ST_STOP) && (state_d[t] != ST_BRAKE);
    end
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= 16'd0;
      pwm_cnt_q  <= 8'd0;
      cmd_q      <= 4'd0;
      state_q[0] <= ST_STOP;
      state_q[1] <= ST_STOP;
      duty_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= 2'b00;
      pwm_q      <= 2'b00;
      brake_q    <= 2'b00;
      busy_q     <= 2'b00;
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      cmd_q      <= cmd;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      duty_q     <= duty_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      pwm_q      <= pwm_d;
      brake_q    <= brake_d;
      busy_q     <= busy_d;
    end
  end

  assign pwm_l   = pwm_q[0];
  assign pwm_r   = pwm_q[1];
  assign dir_l   = dir_q[0];
  assign dir_r   = dir_q[1];
  assign brake_l = brake_q[0];
  assign brake_r = brake_q[1];
  assign busy    = busy_q;

endmodule

// File: tb/tb_track_motor_driver.sv
module tb_track_motor_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] cmd;
  logic       enable;
  logic       pwm_l, pwm_r, dir_l, dir_r, brake_l, brake_r;
  logic [1:0] busy;

  int total = 0;
  int bad   = 0;

  track_motor_driver #(
    .PRESCALE(0), .RAMP_DIV(1), .DEAD_TICKS(4), .MAX_DUTY(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd), .enable(enable),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .brake_l(brake_l), .brake_r(brake_r), .busy(busy)
  );

  always #5 clk = ~clk;

  // {busy, brake_r, brake_l, dir_r, dir_l, pwm_r, pwm_l}
  wire [7:0] outs = {busy, brake_r, brake_l, dir_r, dir_l, pwm_r, pwm_l};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int highs;
  int min_duty;

  initial begin
    reset_n = 1'b0;
    cmd     = 4'b0000;
    enable  = 1'b1;
    cyc(3);
    chk("reset_outs", 16'(outs), 16'h0000);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_outs", 16'(outs), 16'h0000);

    // Left forward ramp 0..8, then RUN.
    cmd = 4'b0001;
    cyc(2);
    chk("fwd_dir_busy", 16'({busy, dir_l}), 16'b011);
    chk("fwd_duty0", 16'(dut.duty_q[0]), 16'd0);
    cyc(4);
    chk("fwd_duty4", 16'(dut.duty_q[0]), 16'd4);
    cyc(4);
    chk("fwd_duty8", 16'(dut.duty_q[0]), 16'd8);
    cyc(2);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (pwm_l) highs++;
    end
    chk("run_pwm_highs", 16'(highs), 16'd8);
    chk("right_idle", 16'({busy[1], brake_r, pwm_r}), 16'd0);
    chk("run_busy", 16'(busy), 16'b01);

    // Reverse request: ramp down, dead 4 ticks, then reverse ramp up.
    cmd = 4'b0010;
    cyc(10);
    chk("rd_duty0", 16'(dut.duty_q[0]), 16'd0);
    cyc(2);
    chk("dead_outs", 16'({busy[0], dir_l, pwm_l}), 16'b110);
    cyc(2);
    chk("dead_dir_hold", 16'(dir_l), 16'd1);
    cyc(1);
    chk("stop_after_dead", 16'({busy[0], dir_l}), 16'b01);
    cyc(1);
    chk("rev_ramp_start", 16'({busy[0], dir_l}), 16'b10);
    cyc(10);
    chk("rev_run_duty", 16'(dut.duty_q[0]), 16'd8);

    // Right ramp up then brake mid-ramp.
    cmd = 4'b0110;
    cyc(7);
    chk("r_duty5", 16'(dut.duty_q[1]), 16'd5);
    cmd = 4'b1110;
    cyc(2);
    chk("r_brake", 16'({busy[1], brake_r, pwm_r}), 16'b010);
    chk("r_brake_duty", 16'(dut.duty_q[1]), 16'd0);
    cmd = 4'b0010;
    cyc(2);
    chk("r_dead", 16'({busy[1], brake_r}), 16'b10);
    cyc(3);
    chk("r_dead_hold", 16'(busy[1]), 16'd1);
    cyc(1);
    chk("r_stop", 16'(busy[1]), 16'd0);

    // Left ramp down to 3, same-direction request resumes from 3.
    cmd = 4'b0000;
    cyc(6);
    cmd = 4'b0010;
    cyc(2);
    chk("resume_duty3", 16'(dut.duty_q[0]), 16'd3);
    min_duty = 255;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (int'(dut.duty_q[0]) < min_duty) min_duty = int'(dut.duty_q[0]);
      chk("resume_nodead", 16'({busy[0], dir_l}), 16'b10);
    end
    chk("resume_min", 16'(min_duty), 16'd4);
    chk("resume_duty8", 16'(dut.duty_q[0]), 16'd8);

    // Both running, then disable and re-enable.
    cmd = 4'b1010;
    cyc(12);
    chk("both_run", 16'({dut.duty_q[1], dut.duty_q[0]}), 16'h0808);
    enable = 1'b0;
    cyc(1);
    chk("disable_outs", 16'({busy, brake_r, brake_l, pwm_r, pwm_l}), 16'd0);
    chk("disable_duty", 16'({dut.duty_q[1], dut.duty_q[0]}), 16'h0000);
    cmd = 4'b1111;
    cyc(3);
    chk("disable_over_brake", 16'({busy, brake_r, brake_l}), 16'd0);
    cmd = 4'b1010;
    cyc(2);
    enable = 1'b1;
    cyc(1);
    chk("reenable_busy", 16'(busy), 16'b11);
    cyc(1);
    chk("reenable_duty1", 16'({dut.duty_q[1], dut.duty_q[0]}), 16'h0101);

    // Asynchronous reset mid-ramp.
    cyc(2);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 16'(outs), 16'h0000);
    chk("async_reset_duty", 16'({dut.duty_q[1], dut.duty_q[0]}), 16'h0000);
    cyc(2);
    reset_n = 1'b1;
    cmd = 4'b0101;
    cyc(1);
    chk("post_reset_quiet", 16'(outs), 16'h0000);
    cyc(1);
    chk("post_reset_start", 16'({busy, dir_r, dir_l}), 16'b1111);
    cyc(2);
    chk("post_reset_duty2", 16'({dut.duty_q[1], dut.duty_q[0]}), 16'h0202);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
